// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding plus the data width and
// default burst/timeout constants used by the transmitter, receiver and arbiter.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_MAX_BURST   = 4;
    localparam int UART_ACK_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_ACK,
        WAIT_DONE
    } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The master modport is the arbiter side; slave is the requester/transmitter side.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic                      err_timeout;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, grant, tx_data, tx_start, err_timeout
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, grant, tx_data, tx_start, err_timeout
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NUM_REQ, returned one-hot together with an any-request flag.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               any_o
);

    localparam int SW = PTR_W + 1;

    logic [SW-1:0] idx;

    // One extra bit on idx lets ptr + offset exceed NUM_REQ before the wrap.
    always_comb begin
        winner_o = '0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_i} + SW'(i);
            if (idx >= SW'(NUM_REQ)) begin
                idx = idx - SW'(NUM_REQ);
            end
            if (winner_o == '0 && req_i[idx[PTR_W-1:0]]) begin
                winner_o[idx[PTR_W-1:0]] = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Define UART_ARB_BURST_EN to let a winner send up to MAX_BURST bytes per grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int MAX_BURST   = UART_MAX_BURST,
    parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15 ||
        ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_cfg
        $error("uart_tx_arbiter: parameter out of range");
    end

    uart_arb_state_t    state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   w_q, w_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [7:0]         ack_cnt_q, ack_cnt_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [DATA_W-1:0]  sel_data;
    logic               burst_more;
    logic               start_pulse;
    logic               timeout_pulse;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i    (bus.req_valid),
        .ptr_i    (rr_ptr_q),
        .winner_o (pick_onehot),
        .any_o    (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) pick_idx = PTR_W'(i);
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_q == PTR_W'(i)) sel_data = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // The owner just served drops to lowest priority on the next arbitration.
    assign next_ptr = (w_q == PTR_W'(NUM_REQ - 1)) ? '0 : w_q + PTR_W'(1);

`ifdef UART_ARB_BURST_EN
    logic [3:0] burst_cnt_q, burst_cnt_d;

    assign burst_more = bus.req_valid[w_q] && (burst_cnt_q < 4'(MAX_BURST));
`else
    assign burst_more = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        w_d           = w_q;
        rr_ptr_d      = rr_ptr_q;
        tx_data_d     = tx_data_q;
        ack_cnt_d     = ack_cnt_q;
`ifdef UART_ARB_BURST_EN
        burst_cnt_d   = burst_cnt_q;
`endif
        start_pulse   = 1'b0;
        timeout_pulse = 1'b0;

        case (state_q)
            // A busy transmitter here means a frame survived reset; wait it out.
            IDLE: begin
                if (pick_any && !bus.tx_busy) begin
                    grant_d = pick_onehot;
                    w_d     = pick_idx;
`ifdef UART_ARB_BURST_EN
                    burst_cnt_d = '0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (bus.req_valid[w_q]) begin
                    tx_data_d = sel_data;
`ifdef UART_ARB_BURST_EN
                    burst_cnt_d = burst_cnt_q + 4'd1;
`endif
                    state_d   = START;
                end else begin
                    rr_ptr_d = next_ptr;
                    grant_d  = '0;
                    state_d  = IDLE;
                end
            end
            START: begin
                start_pulse = 1'b1;
                ack_cnt_d   = '0;
                state_d     = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    timeout_pulse = 1'b1;
                    rr_ptr_d      = next_ptr;
                    grant_d       = '0;
                    state_d       = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (burst_more) begin
                        state_d = LOAD;
                    end else begin
                        rr_ptr_d = next_ptr;
                        grant_d  = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            w_q       <= '0;
            rr_ptr_q  <= '0;
            tx_data_q <= '0;
            ack_cnt_q <= '0;
`ifdef UART_ARB_BURST_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            w_q       <= w_d;
            rr_ptr_q  <= rr_ptr_d;
            tx_data_q <= tx_data_d;
            ack_cnt_q <= ack_cnt_d;
`ifdef UART_ARB_BURST_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.req_ready   = (state_q == LOAD) ? grant_q : '0;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = start_pulse;
    assign bus.err_timeout = timeout_pulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter; the transmitter busy flag is driven by hand.
// Expectations follow UART_ARB_BURST_EN when it is defined for the build.
module tb_uart_tx_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int testCount = 0;
    int failCount = 0;

`ifdef UART_ARB_BURST_EN
    localparam int RESTART_GAP = 2;
`else
    localparam int RESTART_GAP = 3;
`endif

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .DATA_W      (8),
        .MAX_BURST   (4),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic setReq(input int idx, input logic v, input logic [7:0] d);
        bus.req_valid[idx]       = v;
        bus.req_data[idx*8 +: 8] = d;
    endtask

    task automatic doReset;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic waitStart(input int maxCyc, output int cyc);
        cyc = 0;
        while (bus.tx_start !== 1'b1 && cyc < maxCyc) begin
            tick;
            cyc++;
        end
    endtask

    task automatic serveFrame(input int len);
        bus.tx_busy = 1'b1;
        repeat (len) tick;
        bus.tx_busy = 1'b0;
    endtask

    // Reset state with every input idle.
    task automatic test_reset;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        #2 rst_n = 1'b0;
        tick;
        testCount++; if (bus.grant !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_grant got %b want %b", bus.grant, 4'b0000); end
        testCount++; if (bus.req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_ready got %b want %b", bus.req_ready, 4'b0000); end
        testCount++; if (bus.tx_data !== 8'h00) begin failCount++; $display("[TB] FAIL reset_tx_data got %h want %h", bus.tx_data, 8'h00); end
        testCount++; if (bus.tx_start !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tx_start got %b want %b", bus.tx_start, 1'b0); end
        testCount++; if (bus.err_timeout !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err_timeout got %b want %b", bus.err_timeout, 1'b0); end
    endtask

    // One requester: latency, data, and no restart while the frame is running.
    task automatic test_single;
        int   cyc;
        logic sawStart;
        doReset;
        setReq(0, 1'b1, 8'h55);
        tick;
        testCount++; if (bus.grant !== 4'b0001) begin failCount++; $display("[TB] FAIL single_grant got %b want %b", bus.grant, 4'b0001); end
        testCount++; if (bus.req_ready !== 4'b0001) begin failCount++; $display("[TB] FAIL single_ready got %b want %b", bus.req_ready, 4'b0001); end
        testCount++; if (bus.tx_start !== 1'b0) begin failCount++; $display("[TB] FAIL single_early_start got %b want %b", bus.tx_start, 1'b0); end
        tick;
        testCount++; if (bus.tx_start !== 1'b1) begin failCount++; $display("[TB] FAIL single_start got %b want %b", bus.tx_start, 1'b1); end
        testCount++; if (bus.tx_data !== 8'h55) begin failCount++; $display("[TB] FAIL single_data got %h want %h", bus.tx_data, 8'h55); end
        testCount++; if (bus.req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL single_ready_clear got %b want %b", bus.req_ready, 4'b0000); end
        setReq(0, 1'b1, 8'hA3);
        bus.tx_busy = 1'b1;
        sawStart = 1'b0;
        repeat (8) begin
            tick;
            if (bus.tx_start !== 1'b0) sawStart = 1'b1;
        end
        testCount++; if (sawStart !== 1'b0) begin failCount++; $display("[TB] FAIL single_start_while_busy got %b want %b", sawStart, 1'b0); end
        bus.tx_busy = 1'b0;
        waitStart(10, cyc);
        testCount++; if (cyc != RESTART_GAP) begin failCount++; $display("[TB] FAIL single_restart_gap got %0d want %0d", cyc, RESTART_GAP); end
        testCount++; if (bus.tx_data !== 8'hA3) begin failCount++; $display("[TB] FAIL single_second_data got %h want %h", bus.tx_data, 8'hA3); end
        setReq(0, 1'b0, 8'h00);
        serveFrame(4);
        tick;
        tick;
    endtask

    // All requesters valid at once: fair rotation and a one-hot grant.
    task automatic test_round_robin;
        int   cyc;
        logic twoHot;
`ifdef UART_ARB_BURST_EN
        int expOrder[5] = '{0, 0, 0, 0, 1};
`else
        int expOrder[5] = '{0, 1, 2, 3, 0};
`endif
        doReset;
        for (int i = 0; i < 4; i++) setReq(i, 1'b1, 8'(8'h10 + i));
        twoHot = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            while (bus.tx_start !== 1'b1 && cyc < 12) begin
                tick;
                cyc++;
                if ($countones(bus.grant) > 1) twoHot = 1'b1;
            end
            testCount++; if (bus.tx_start !== 1'b1) begin failCount++; $display("[TB] FAIL rr_start[%0d] got %b want %b", k, bus.tx_start, 1'b1); end
            testCount++; if (bus.grant !== 4'(1 << expOrder[k])) begin failCount++; $display("[TB] FAIL rr_owner[%0d] got %b want %b", k, bus.grant, 4'(1 << expOrder[k])); end
            testCount++; if (bus.tx_data !== 8'(8'h10 + expOrder[k])) begin failCount++; $display("[TB] FAIL rr_data[%0d] got %h want %h", k, bus.tx_data, 8'(8'h10 + expOrder[k])); end
            bus.tx_busy = 1'b1;
            repeat (4) begin
                tick;
                if ($countones(bus.grant) > 1) twoHot = 1'b1;
            end
            bus.tx_busy = 1'b0;
        end
        testCount++; if (twoHot !== 1'b0) begin failCount++; $display("[TB] FAIL rr_grant_two_hot got %b want %b", twoHot, 1'b0); end
        bus.req_valid = '0;
        repeat (6) tick;
    endtask

    // Requester 1 withdraws during LOAD; requester 2 must win the next round.
    task automatic test_withdraw;
        int   cyc;
        logic sawStart;
        doReset;
        setReq(1, 1'b1, 8'h11);
        tick;
        testCount++; if (bus.req_ready !== 4'b0010) begin failCount++; $display("[TB] FAIL wd_ready got %b want %b", bus.req_ready, 4'b0010); end
        setReq(1, 1'b0, 8'h00);
        tick;
        testCount++; if (bus.grant !== 4'b0000) begin failCount++; $display("[TB] FAIL wd_grant_clear got %b want %b", bus.grant, 4'b0000); end
        sawStart = bus.tx_start;
        repeat (3) begin
            tick;
            if (bus.tx_start !== 1'b0) sawStart = 1'b1;
        end
        testCount++; if (sawStart !== 1'b0) begin failCount++; $display("[TB] FAIL wd_no_start got %b want %b", sawStart, 1'b0); end
        setReq(0, 1'b1, 8'hA0);
        setReq(1, 1'b1, 8'hA1);
        setReq(2, 1'b1, 8'hA2);
        waitStart(10, cyc);
        testCount++; if (bus.grant !== 4'b0100) begin failCount++; $display("[TB] FAIL wd_next_owner got %b want %b", bus.grant, 4'b0100); end
        testCount++; if (bus.tx_data !== 8'hA2) begin failCount++; $display("[TB] FAIL wd_next_data got %h want %h", bus.tx_data, 8'hA2); end
        bus.req_valid = '0;
        serveFrame(3);
        repeat (3) tick;
    endtask

    // Transmitter never acknowledges: err_timeout 15 cycles after tx_start.
    task automatic test_timeout;
        int cyc;
        int n;
        doReset;
        setReq(3, 1'b1, 8'hC3);
        waitStart(10, cyc);
        testCount++; if (bus.tx_start !== 1'b1) begin failCount++; $display("[TB] FAIL to_start got %b want %b", bus.tx_start, 1'b1); end
        setReq(3, 1'b0, 8'h00);
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        testCount++; if (n != 15) begin failCount++; $display("[TB] FAIL to_delay got %0d want %0d", n, 15); end
        tick;
        testCount++; if (bus.err_timeout !== 1'b0) begin failCount++; $display("[TB] FAIL to_pulse_width got %b want %b", bus.err_timeout, 1'b0); end
        testCount++; if (bus.grant !== 4'b0000) begin failCount++; $display("[TB] FAIL to_grant got %b want %b", bus.grant, 4'b0000); end
    endtask

    // Reset lands while a frame is in flight; the arbiter must wait for busy to fall.
    task automatic test_reset_mid_frame;
        int   cyc;
        logic bad;
        doReset;
        setReq(1, 1'b1, 8'h99);
        waitStart(10, cyc);
        setReq(1, 1'b0, 8'h00);
        bus.tx_busy = 1'b1;
        repeat (3) tick;
        testCount++; if (bus.grant !== 4'b0010) begin failCount++; $display("[TB] FAIL mid_grant_before got %b want %b", bus.grant, 4'b0010); end
        rst_n = 1'b0;
        #1;
        testCount++; if (bus.grant !== 4'b0000) begin failCount++; $display("[TB] FAIL mid_grant_reset got %b want %b", bus.grant, 4'b0000); end
        testCount++; if (bus.tx_data !== 8'h00) begin failCount++; $display("[TB] FAIL mid_data_reset got %h want %h", bus.tx_data, 8'h00); end
        tick;
        rst_n = 1'b1;
        setReq(0, 1'b1, 8'h5A);
        bad = 1'b0;
        repeat (5) begin
            tick;
            if (bus.tx_start !== 1'b0 || bus.grant !== 4'b0000) bad = 1'b1;
        end
        testCount++; if (bad !== 1'b0) begin failCount++; $display("[TB] FAIL mid_hold_while_busy got %b want %b", bad, 1'b0); end
        bus.tx_busy = 1'b0;
        waitStart(10, cyc);
        testCount++; if (bus.tx_start !== 1'b1) begin failCount++; $display("[TB] FAIL mid_resume_start got %b want %b", bus.tx_start, 1'b1); end
        testCount++; if (bus.grant !== 4'b0001) begin failCount++; $display("[TB] FAIL mid_resume_owner got %b want %b", bus.grant, 4'b0001); end
        bus.req_valid = '0;
        serveFrame(3);
        repeat (3) tick;
    endtask

`ifdef UART_ARB_BURST_EN
    // Requester 2 keeps a burst of MAX_BURST bytes, then requester 0 wins.
    task automatic test_burst;
        int cyc;
        doReset;
        setReq(2, 1'b1, 8'hB2);
        tick;
        setReq(0, 1'b1, 8'hB0);
        for (int k = 0; k < 4; k++) begin
            waitStart(12, cyc);
            testCount++; if (bus.grant !== 4'b0100) begin failCount++; $display("[TB] FAIL burst_owner[%0d] got %b want %b", k, bus.grant, 4'b0100); end
            serveFrame(4);
        end
        waitStart(12, cyc);
        testCount++; if (bus.grant !== 4'b0001) begin failCount++; $display("[TB] FAIL burst_handover got %b want %b", bus.grant, 4'b0001); end
        testCount++; if (bus.tx_data !== 8'hB0) begin failCount++; $display("[TB] FAIL burst_handover_data got %h want %h", bus.tx_data, 8'hB0); end
        bus.req_valid = '0;
        serveFrame(3);
        repeat (3) tick;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_withdraw;
        test_timeout;
        test_reset_mid_frame;
`ifdef UART_ARB_BURST_EN
        test_burst;
`endif
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired after %0d tests", testCount);
        $fatal(1, "[TB] watchdog");
    end

endmodule
